// File: rtl/led_blinker_pkg.sv
// rtl/led_blinker_pkg.sv - shared state encoding, default timing constants and helpers for led_blinker
package led_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_e;

  localparam int TICK_DIV_DEF  = 4;
  localparam int ON_TICKS_DEF  = 3;
  localparam int OFF_TICKS_DEF = 2;
  localparam int PWM_BITS_DEF  = 4;
  localparam int PEND_W_DEF    = 3;

  // Window lengths in clock cycles for the default timing.
  localparam int ON_CYC  = ON_TICKS_DEF * TICK_DIV_DEF;
  localparam int GAP_CYC = OFF_TICKS_DEF * TICK_DIV_DEF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_blinker_tick_gen.sv
// rtl/led_blinker_tick_gen.sv - clock prescaler producing one tick every TICK_DIV enabled cycles
module tick_gen
  import led_blinker_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider count: clear wins so every window starts on a fresh tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - turns request strobes into queued, PWM-dimmed LED blinks
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int PEND_W    = PEND_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_pulse,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led_out,
  output logic                busy,
  output logic [PEND_W-1:0]   pending,
  output logic                dropped
);

  localparam int              PH_W     = cnt_width((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_e        state, state_next;
  logic [PH_W-1:0]     phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                tick_en;
  logic                tick_clear;
  logic                req_avail;
  logic                consume;
  logic                phase_wrap;

  assign tick_en    = (state != IDLE);
  assign tick_clear = (state == IDLE) || consume;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; a GAP that ends with work waiting goes straight back to ON.
  always_comb begin
    state_next = state;
    consume    = 1'b0;
    phase_wrap = 1'b0;
    req_avail  = in_pulse || (pending != '0);
    case (state)
      IDLE: begin
        if (req_avail) begin
          state_next = ON;
          consume    = 1'b1;
        end
      end
      ON: begin
        if (tick && (phase == ON_LAST)) begin
          state_next = GAP;
          phase_wrap = 1'b1;
        end
      end
      GAP: begin
        if (tick && (phase == GAP_LAST)) begin
          phase_wrap = 1'b1;
          if (req_avail) begin
            state_next = ON;
            consume    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick count within the current ON or GAP window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (consume || phase_wrap || (state == IDLE)) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + PH_W'(1);
    end
  end

  // PWM ramp restarts at every blink so each blink has the same shape.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (consume) begin
      pwm_cnt <= '0;
    end else if (state == ON) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Pending queue: a consuming edge eats one request (possibly the incoming one).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (consume) begin
      pending <= in_pulse ? pending : pending - PEND_W'(1);
    end else if (in_pulse && (pending != PEND_MAX)) begin
      pending <= pending + PEND_W'(1);
    end
  end

  // Drop strobe for a request that found the queue full and nothing consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped <= 1'b0;
    end else begin
      dropped <= in_pulse && !consume && (pending == PEND_MAX);
    end
  end

  // LED drive: PWM compare only while ON, registered to keep the pin glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 1'b0;
    end else begin
      led_out <= (state == ON) && (pwm_cnt < duty);
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_led_blinker.sv
// tb/tb_led_blinker.sv - self-checking bench for led_blinker
module tb_led_blinker;
  import led_blinker_pkg::*;

  localparam int PERIOD   = ON_CYC + GAP_CYC;
  localparam int PEND_MAX = (1 << PEND_W_DEF) - 1;
  localparam int PWM_MOD  = 1 << PWM_BITS_DEF;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_pulse;
  logic [3:0] duty;
  logic       led_out;
  logic       busy;
  logic [2:0] pending;
  logic       dropped;

  always #5 clk = ~clk;

  led_blinker dut (
    .clk      (clk),
    .reset    (reset),
    .in_pulse (in_pulse),
    .duty     (duty),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .dropped  (dropped)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: a blink is a PERIOD-cycle slot; pos counts cycles since ON entry.
  bit m_active;
  int m_pos, m_pend, m_led, m_drop;

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_pend = 0; m_led = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit p, input int d);
    bit avail, ends, take;
    avail  = p || (m_pend > 0);
    ends   = m_active && (m_pos == PERIOD - 1);
    take   = avail && (!m_active || ends);
    m_led  = (m_active && (m_pos < ON_CYC) && ((m_pos % PWM_MOD) < d)) ? 1 : 0;
    m_drop = (p && !take && (m_pend == PEND_MAX)) ? 1 : 0;
    m_pend = m_pend + int'(p) - int'(take);
    if (m_pend > PEND_MAX) m_pend = PEND_MAX;
    if (take) begin
      m_active = 1; m_pos = 0;
    end else if (ends) begin
      m_active = 0; m_pos = 0;
    end else if (m_active) begin
      m_pos++;
    end
  endtask

  task automatic cycle(input bit p, input int d);
    in_pulse = p;
    duty     = 4'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_pulse = 1'b0; duty = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int n_pulses;
    int duty;
    int exp_high;
    int exp_run;
    int exp_blinks;
    int exp_busy;
    int exp_drops;
    int exp_maxpend;
    int exp_first;
  } scen_t;

  scen_t tbl[6];
  int    led_s[64];
  int    busy_s[64];
  int    pend_s[64];

  initial begin
    tbl[0] = '{1, 15, 12, 12, 1, 20, 0, 0, 2};
    tbl[1] = '{1, 4, 4, 4, 1, 20, 0, 0, 2};
    tbl[2] = '{1, 0, 0, 0, 0, 20, 0, 0, -1};
    tbl[3] = '{3, 15, 36, 12, 3, 60, 0, 2, 2};
    tbl[4] = '{10, 15, 96, 12, 8, 160, 2, 7, 2};
    tbl[5] = '{2, 8, 16, 8, 2, 40, 0, 1, 2};

    // Reset state.
    do_reset();
    check("reset led_out", led_out, 0);
    check("reset busy", busy, 0);
    check("reset pending", pending, 0);
    check("reset dropped", dropped, 0);

    // Table scenarios: burst of pulses, then observe the whole episode.
    for (int s = 0; s < 6; s++) begin
      int high, run, best_run, blinks, busy_n, drops, maxp, first, prev;
      do_reset();
      high = 0; run = 0; best_run = 0; blinks = 0; busy_n = 0;
      drops = 0; maxp = 0; first = -1; prev = 0;
      for (int c = 0; c < 200; c++) begin
        cycle(c < tbl[s].n_pulses, tbl[s].duty);
        if (led_out) begin
          high++; run++;
          if (run > best_run) best_run = run;
          if (!prev) blinks++;
          if (first < 0) first = c + 1;
        end else begin
          run = 0;
        end
        prev = int'(led_out);
        if (busy) busy_n++;
        if (dropped) drops++;
        if (int'(pending) > maxp) maxp = int'(pending);
      end
      check($sformatf("tbl%0d high cycles", s), high, tbl[s].exp_high);
      check($sformatf("tbl%0d longest run", s), best_run, tbl[s].exp_run);
      check($sformatf("tbl%0d blinks", s), blinks, tbl[s].exp_blinks);
      check($sformatf("tbl%0d busy cycles", s), busy_n, tbl[s].exp_busy);
      check($sformatf("tbl%0d drops", s), drops, tbl[s].exp_drops);
      check($sformatf("tbl%0d max pending", s), maxp, tbl[s].exp_maxpend);
      check($sformatf("tbl%0d first high", s), first, tbl[s].exp_first);
    end

    // Request during GAP: second blink follows the gap with no idle cycle.
    begin
      int idle_n;
      do_reset();
      for (int c = 0; c < 45; c++) begin
        cycle((c == 0) || (c == 15), 15);
        led_s[c+1]  = int'(led_out);
        busy_s[c+1] = int'(busy);
        pend_s[c+1] = int'(pending);
      end
      idle_n = 0;
      for (int e = 1; e <= 40; e++) if (!busy_s[e]) idle_n++;
      check("gap req pending after pulse", pend_s[16], 1);
      check("gap req pending held", pend_s[20], 1);
      check("gap req pending consumed", pend_s[21], 0);
      check("gap req busy gaps", idle_n, 0);
      check("gap req led before 2nd on", led_s[21], 0);
      check("gap req led 2nd on start", led_s[22], 1);
      check("gap req led 2nd on end", led_s[33], 1);
      check("gap req led after 2nd on", led_s[34], 0);
      check("gap req busy end", busy_s[41], 0);
    end

    // Reset mid-ON with two queued requests.
    begin
      int busy_n, high;
      do_reset();
      for (int c = 0; c < 6; c++) cycle(c < 3, 15);
      check("midon pending before reset", pending, 2);
      check("midon led before reset", led_out, 1);
      #2;
      reset = 1'b1;
      #1;
      check("midon async led", led_out, 0);
      check("midon async busy", busy, 0);
      check("midon async pending", pending, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      busy_n = 0; high = 0;
      for (int c = 0; c < 40; c++) begin
        cycle(1'b0, 15);
        if (busy) busy_n++;
        if (led_out) high++;
      end
      check("midon no blink busy", busy_n, 0);
      check("midon no blink led", high, 0);
    end

    // Randomized traffic against the reference model.
    begin
      int pct, d;
      bit p;
      do_reset();
      pct = 20; d = 9;
      for (int k = 0; k < 3000; k++) begin
        if (k % 250 == 0) begin
          case ($urandom_range(3))
            0: pct = 5;
            1: pct = 20;
            2: pct = 50;
            default: pct = 90;
          endcase
        end
        if ($urandom_range(9) == 0) d = int'($urandom_range(15));
        if (k == 1500) begin
          #2;
          reset = 1'b1;
          #1;
          check("rand async busy", busy, 0);
          @(posedge clk);
          #1;
          reset = 1'b0;
          model_reset();
        end
        p = ($urandom_range(99) < pct);
        model_step(p, d);
        cycle(p, d);
        check($sformatf("rand led @%0d", k), led_out, m_led);
        check($sformatf("rand dropped @%0d", k), dropped, m_drop);
        check($sformatf("rand pending @%0d", k), pending, m_pend);
        check($sformatf("rand busy @%0d", k), busy, (m_active || (m_pend > 0)) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_blinker.md
# led_blinker

Output-side companion to the button filter in the LED controller. It takes single-cycle event strobes, such as a filtered button-press enable, and turns each one into a human-visible LED blink. Each blink has a fixed ON window, a fixed OFF gap and PWM-controlled brightness. Requests that arrive while a blink is in progress are queued in a saturating pending counter and played back in order.

## Interface
- TICK_DIV, 4: clock cycles per timing tick (≥1)
- ON_TICKS, 3: ticks per ON window (≥1)
- OFF_TICKS, 2: ticks per OFF gap (≥1)
- PWM_BITS, 4: width of duty input and PWM counter
- PEND_W, 3: width of pending counter; saturates at 2^PEND_W−1
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_pulse  input  1  blink request, sampled every cycle; one request per high cycle
- duty  input  PWM_BITS  brightness; sampled every cycle
- led_out  output  1  registered LED drive
- busy  output  1  high when state≠IDLE or pending≠0
- pending  output  PEND_W  queued requests not yet started
- dropped  output  1  registered one-cycle strobe: request lost to saturation

## Operation
- Reset values: state=IDLE, pending=0, led_out=0, dropped=0, and tick, phase and PWM counters all 0.
- FSM states: IDLE, ON, GAP.
- A request is available when in_pulse=1 or pending≠0.
- IDLE → ON when a request is available.
- ON → GAP after ON_TICKS ticks.
- GAP → ON after OFF_TICKS ticks if a request is available; otherwise GAP → IDLE.
- Each entry into ON consumes one request and clears the tick counter, phase counter and PWM counter.
- Pending update on a consuming edge: pending + in_pulse − 1.
- Pending update otherwise: pending + in_pulse, saturating at 2^PEND_W−1.
- If in_pulse arrives while pending is saturated and no request is consumed that cycle, the pulse is dropped and dropped=1 on the next cycle.
- An in_pulse on a consuming edge is never dropped.
- Tick counter counts 0..TICK_DIV−1 and emits a tick on wrap. It is free-running in ON and GAP and held at 0 in IDLE.
- PWM counter is free-running, mod 2^PWM_BITS, in ON.
- led_out next value = (state==ON) && (pwm_cnt < duty). duty=0 gives the LED permanently off.
- In GAP and IDLE, led_out next value = 0.

## Timing
- in_pulse high in cycle 0 while IDLE: state=ON after edge 1; led_out rises after edge 2.
- ON window occupies exactly ON_TICKS·TICK_DIV cycles.
- GAP occupies exactly OFF_TICKS·TICK_DIV cycles.
- led_out lags state by one cycle.
- Back-to-back blinks: ON windows are separated by exactly OFF_TICKS·TICK_DIV cycles. There is no extra IDLE cycle.
- Reset asserted mid-ON or mid-GAP forces all outputs to their reset values immediately, without waiting for a clock edge. Queued requests are discarded.
- busy is combinational from registered state and pending, so it has no extra latency.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, ON=2'd1, GAP=2'd2)
  - localparams ON_CYC = ON_TICKS·TICK_DIV and GAP_CYC = OFF_TICKS·TICK_DIV
- Sub-module tick_gen: prescaler with clk, reset, clear and enable inputs and a tick output.
- FSM, pending counter and PWM comparator live in led_blinker.

## Test plan
All scenarios use default parameters unless stated.
- **Single blink, full brightness:** in_pulse for 1 cycle, duty=15 → led_out high for 12 consecutive cycles starting 2 cycles after the pulse, then low; busy high for 20 cycles; pending stays 0.
- **Single blink, partial duty:** in_pulse for 1 cycle, duty=4 → within the 12-cycle window, led_out high 4 cycles then low 8. With duty=0, led_out stays 0 while busy is still high for 20 cycles.
- **Queued requests:** three pulses on consecutive cycles → pending reads 1, then 2; exactly three 12-cycle high windows separated by 8 low cycles; busy falls 60 cycles after the first ON entry.
- **Saturation:** 10 consecutive pulses → first consumed, pending reaches 7, dropped pulses twice, exactly 8 blinks produced.
- **Request during GAP:** pulse arrives mid-GAP → pending=1 until GAP ends; ON entered directly with no IDLE cycle; pending returns to 0.
- **Reset mid-ON:** reset asserted 5 cycles into ON with pending=2 → led_out, busy and pending go to 0 without a clock edge; after release, no blink occurs until a new pulse.
